// File: rtl/crp16_boot_loader_pkg.sv
// crp16_boot_loader_pkg: shared state encoding and widths for the program loader
package crp16_boot_loader_pkg;
  localparam int WORD_W = 16;
  localparam int BYTE_W = 8;
  localparam int CSUM_W = 8;
  typedef enum logic [2:0] {
    ST_CNT_LO, ST_CNT_HI, ST_DATA_LO, ST_DATA_HI, ST_WRITE, ST_CSUM, ST_RUN, ST_ERROR
  } state_t;
endpackage

// File: rtl/crp16_boot_loader_if.sv
// crp16_boot_loader_if: host byte link plus RAM port A as seen by the loader
interface crp16_boot_loader_if;
  import crp16_boot_loader_pkg::*;
  logic [BYTE_W-1:0] byte_in;
  logic byte_valid;
  logic byte_ready;
  logic [WORD_W-1:0] ram_address_a;
  logic [WORD_W-1:0] ram_data_a;
  logic ram_wren_a;
  logic [WORD_W-1:0] ram_q_a;
  modport slave (
    input byte_in, byte_valid, ram_q_a,
    output byte_ready, ram_address_a, ram_data_a, ram_wren_a
  );
  modport master (
    output byte_in, byte_valid, ram_q_a,
    input byte_ready, ram_address_a, ram_data_a, ram_wren_a
  );
endinterface

// File: rtl/crp16_boot_loader_byte_assembler.sv
// crp16_boot_loader_byte_assembler: joins a little-endian byte pair into a word with a valid strobe
module crp16_boot_loader_byte_assembler
  import crp16_boot_loader_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic lo_en,
  input  logic hi_en,
  output logic [WORD_W-1:0] word,
  output logic word_valid
);
  logic [BYTE_W-1:0] lo, hi;
  always_ff @(posedge clock) begin
    if (reset) begin
      lo <= '0;
      hi <= '0;
      word_valid <= 1'b0;
    end else begin
      if (lo_en) lo <= byte_in;
      if (hi_en) hi <= byte_in;
      word_valid <= hi_en;
    end
  end
  assign word = {hi, lo};
endmodule

// File: rtl/crp16_boot_loader.sv
// crp16_boot_loader: receives a framed program image into RAM port A, then releases the core
module crp16_boot_loader
  import crp16_boot_loader_pkg::*;
#(
  parameter logic [WORD_W-1:0] LOAD_BASE = 16'h0000
) (
  input  logic clock,
  input  logic reset,
  crp16_boot_loader_if.slave bus,
  input  logic load_req,
  output logic cpu_reset,
  input  logic [WORD_W-1:0] cpu_address_a,
  output logic [WORD_W-1:0] cpu_q_a,
  output logic loading,
  output logic load_error
);
  state_t state;
  logic [WORD_W-1:0] count, index, word;
  logic [CSUM_W-1:0] csum;
  logic accept, word_valid, run;
  assign run = state == ST_RUN;
  assign loading = state inside {ST_CNT_LO, ST_CNT_HI, ST_DATA_LO, ST_DATA_HI, ST_WRITE, ST_CSUM};
  assign bus.byte_ready = loading && state != ST_WRITE;
  assign accept = bus.byte_valid && bus.byte_ready;
  // RUN hands port A to the core's fetch; the read path stays combinational
  assign bus.ram_address_a = run ? cpu_address_a : LOAD_BASE + index;
  assign bus.ram_data_a = word;
  assign bus.ram_wren_a = state == ST_WRITE && word_valid;
  assign cpu_q_a = run ? bus.ram_q_a : '0;
  crp16_boot_loader_byte_assembler u_asm (
    .clock(clock),
    .reset(reset),
    .byte_in(bus.byte_in),
    .lo_en(accept && state == ST_DATA_LO),
    .hi_en(accept && state == ST_DATA_HI),
    .word(word),
    .word_valid(word_valid)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_CNT_LO;
      count <= '0;
      index <= '0;
      csum <= '0;
      cpu_reset <= 1'b1;
      load_error <= 1'b0;
    end else begin
      case (state)
        ST_CNT_LO: if (accept) begin
          count[7:0] <= bus.byte_in;
          state <= ST_CNT_HI;
        end
        ST_CNT_HI: if (accept) begin
          count[15:8] <= bus.byte_in;
          state <= {bus.byte_in, count[7:0]} == '0 ? ST_CSUM : ST_DATA_LO;
        end
        ST_DATA_LO: if (accept) begin
          csum <= csum + bus.byte_in;
          state <= ST_DATA_HI;
        end
        ST_DATA_HI: if (accept) begin
          csum <= csum + bus.byte_in;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          index <= index + 16'd1;
          state <= index + 16'd1 == count ? ST_CSUM : ST_DATA_LO;
        end
        ST_CSUM: if (accept) begin
          state <= bus.byte_in == csum ? ST_RUN : ST_ERROR;
          cpu_reset <= bus.byte_in != csum;
          load_error <= bus.byte_in != csum;
        end
        ST_RUN, ST_ERROR: if (load_req) begin
          state <= ST_CNT_LO;
          count <= '0;
          index <= '0;
          csum <= '0;
          cpu_reset <= 1'b1;
          load_error <= 1'b0;
        end
        default: state <= ST_CNT_LO;
      endcase
    end
  end
endmodule

// File: tb/tb_crp16_boot_loader.sv
// tb_crp16_boot_loader: directed image loads against two loaders (base 0000 and FFFF) sharing one byte stream
module tb_crp16_boot_loader;
  logic clock = 1'b0, reset = 1'b1, load_req = 1'b0;
  logic [15:0] cpu_address_a = 16'h0000;
  logic cpu_reset0, cpu_reset1, loading0, loading1, load_error0, load_error1;
  logic [15:0] cpu_q_a0, cpu_q_a1;
  int checks = 0, failures = 0, bad_ready = 0;
  logic [31:0] q0[$], q1[$];

  crp16_boot_loader_if bus0();
  crp16_boot_loader_if bus1();

  crp16_boot_loader #(.LOAD_BASE(16'h0000)) u0 (
    .clock(clock), .reset(reset), .bus(bus0), .load_req(load_req), .cpu_reset(cpu_reset0),
    .cpu_address_a(cpu_address_a), .cpu_q_a(cpu_q_a0), .loading(loading0), .load_error(load_error0)
  );
  crp16_boot_loader #(.LOAD_BASE(16'hFFFF)) u1 (
    .clock(clock), .reset(reset), .bus(bus1), .load_req(load_req), .cpu_reset(cpu_reset1),
    .cpu_address_a(cpu_address_a), .cpu_q_a(cpu_q_a1), .loading(loading1), .load_error(load_error1)
  );

  always #5 clock = ~clock;
  assign bus0.ram_q_a = bus0.ram_address_a ^ 16'h5A5A;
  assign bus1.ram_q_a = bus1.ram_address_a ^ 16'h5A5A;
  assign bus1.byte_in = bus0.byte_in;
  assign bus1.byte_valid = bus0.byte_valid;

  always @(posedge clock) begin
    if (bus0.ram_wren_a) q0.push_back({bus0.ram_address_a, bus0.ram_data_a});
    if (bus1.ram_wren_a) q1.push_back({bus1.ram_address_a, bus1.ram_data_a});
  end
  always @(negedge clock) if (bus0.ram_wren_a && bus0.byte_ready) bad_ready++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int stall);
    int n;
    repeat (stall) begin
      @(negedge clock);
      bus0.byte_valid = 1'b0;
    end
    @(negedge clock);
    bus0.byte_in = b;
    bus0.byte_valid = 1'b1;
    n = 0;
    while (!bus0.byte_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n == 50) chk("ready_timeout", 32'd0, 32'd1);
    @(posedge clock);
    #1 bus0.byte_valid = 1'b0;
  endtask

  task automatic pulse_load;
    @(negedge clock);
    load_req = 1'b1;
    @(posedge clock);
    #1 load_req = 1'b0;
  endtask

  initial begin
    bus0.byte_in = 8'h00;
    bus0.byte_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_cpu_reset", cpu_reset0, 1);
    chk("rst_ready", bus0.byte_ready, 1);
    chk("rst_loading", loading0, 1);
    chk("rst_error", load_error0, 0);
    chk("rst_wren", bus0.ram_wren_a, 0);
    chk("rst_addr", bus1.ram_address_a, 16'hFFFF);
    chk("rst_cpu_q", cpu_q_a0, 0);
    reset = 1'b0;

    send(8'h01, 0); send(8'h00, 0); send(8'h34, 0); send(8'h12, 0);
    chk("t1_pre_csum_reset", cpu_reset0, 1);
    send(8'h46, 0);
    chk("t1_cpu_reset", cpu_reset0, 0);
    chk("t1_loading", loading0, 0);
    chk("t1_error", load_error0, 0);
    chk("t1_nwrites", q0.size(), 1);
    chk("t1_write0", q0[0], 32'h0000_1234);
    chk("t1_write1", q1[0], 32'hFFFF_1234);

    cpu_address_a = 16'h0005;
    #1;
    chk("run_addr", bus0.ram_address_a, 16'h0005);
    chk("run_q", cpu_q_a0, 16'h5A5F);
    cpu_address_a = 16'h1234;
    #1;
    chk("run_q2", cpu_q_a0, 16'h486E);
    chk("run_wren", bus0.ram_wren_a, 0);
    pulse_load;
    chk("reload_cpu_reset", cpu_reset0, 1);
    chk("reload_loading", loading0, 1);
    chk("reload_cpu_q", cpu_q_a0, 0);

    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    chk("c0_cpu_reset", cpu_reset0, 0);
    chk("c0_nwrites", q0.size(), 1);
    pulse_load;

    send(8'h01, 0); send(8'h00, 0); send(8'h34, 0); send(8'h12, 0); send(8'h47, 0);
    repeat (3) @(posedge clock);
    #1;
    chk("bad_error", load_error0, 1);
    chk("bad_cpu_reset", cpu_reset0, 1);
    chk("bad_ready", bus0.byte_ready, 0);
    chk("bad_loading", loading0, 0);
    chk("bad_nwrites", q0.size(), 2);
    pulse_load;
    chk("bad_clear", load_error0, 0);
    chk("bad_reload", loading0, 1);

    send(8'h03, 1); send(8'h00, 0); send(8'h11, 2); send(8'h11, 0); send(8'h22, 1);
    send(8'h22, 0); send(8'hCD, 2); send(8'hAB, 1); send(8'hDE, 0);
    chk("st_cpu_reset", cpu_reset0, 0);
    chk("st_nwrites", q0.size(), 5);
    chk("st_w0", q0[2], 32'h0000_1111);
    chk("st_w1", q0[3], 32'h0001_2222);
    chk("st_w2", q0[4], 32'h0002_ABCD);
    chk("st_b2", q1[4], 32'h0001_ABCD);
    chk("st_ready_in_write", bad_ready, 0);
    pulse_load;

    send(8'h02, 0); send(8'h00, 0); send(8'hAA, 0); send(8'hAA, 0);
    send(8'hBB, 0); send(8'hBB, 0); send(8'hCA, 0);
    chk("wr_cpu_reset", cpu_reset1, 0);
    chk("wr_nwrites", q1.size(), 7);
    chk("wr_w0", q1[5], 32'hFFFF_AAAA);
    chk("wr_w1", q1[6], 32'h0000_BBBB);
    chk("wr_base0", q0[6], 32'h0001_BBBB);

    pulse_load;
    send(8'h02, 0); send(8'h00, 0); send(8'h11, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk("mid_rst_cpu_reset", cpu_reset0, 1);
    chk("mid_rst_addr", bus0.ram_address_a, 16'h0000);
    chk("mid_rst_ready", bus0.byte_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
